// File: rtl/ip_mac_sequencer_pkg.sv
// Shared constants, FSM state encoding and datapath types for the sequential
// inner-product engine (ip_mac_sequencer and ip_mac_unit).
package ip_seq_pkg;

  localparam int N_FEAT     = 81;
  localparam int X_W        = 7;
  localparam int ACC_W      = 32;
  localparam int ADDR_W     = 7;
  localparam int BIAS_SHIFT = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HOLD
  } state_t;

  typedef logic [X_W-1:0]          pixel_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic logic [ACC_W-1:0] zext_pixel(input pixel_t x);
    return {{(ACC_W-X_W){1'b0}}, x};
  endfunction

endpackage

// File: rtl/ip_mac_sequencer_if.sv
// Window / coefficient-ROM / result bus of ip_mac_sequencer. Defining
// IPSEQ_THRESH_OUT_EN adds the class_out sign-threshold output.
interface ip_mac_sequencer_if;
  import ip_seq_pkg::*;

  logic                    win_valid;
  logic                    win_ready;
  logic [N_FEAT*X_W-1:0]   win_data;
  logic [ADDR_W-1:0]       theta_addr;
  logic                    theta_rd;
  logic [ACC_W-1:0]        theta_data;
  logic                    res_valid;
  logic                    res_ready;
  logic [ACC_W-1:0]        hidden;
`ifdef IPSEQ_THRESH_OUT_EN
  logic                    class_out;

  modport master (
    input  win_valid, win_data, theta_data, res_ready,
    output win_ready, theta_addr, theta_rd, res_valid, hidden, class_out
  );
  modport slave (
    output win_valid, win_data, theta_data, res_ready,
    input  win_ready, theta_addr, theta_rd, res_valid, hidden, class_out
  );
`else
  modport master (
    input  win_valid, win_data, theta_data, res_ready,
    output win_ready, theta_addr, theta_rd, res_valid, hidden
  );
  modport slave (
    output win_valid, win_data, theta_data, res_ready,
    input  win_ready, theta_addr, theta_rd, res_valid, hidden
  );
`endif

endinterface

// File: rtl/ip_mac_sequencer_mac.sv
// Shared multiply-accumulate: x and bias-select are registered to line up with
// the ROM's one-cycle read latency; theta arrives already registered by the ROM.
module ip_mac_unit
  import ip_seq_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   en,
  input  logic   bias_sel,
  input  pixel_t x,
  input  acc_t   theta,
  output acc_t   acc_next
);

  pixel_t            x_reg;
  logic              bias_reg;
  logic              en_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [ACC_W-1:0]  theta_u;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg    <= '0;
      bias_reg <= 1'b0;
      en_reg   <= 1'b0;
    end else if (clr) begin
      x_reg    <= '0;
      bias_reg <= 1'b0;
      en_reg   <= 1'b0;
    end else begin
      x_reg    <= x;
      bias_reg <= bias_sel;
      en_reg   <= en;
    end
  end

  // Unsigned multiply truncated to ACC_W gives the same bits as the signed product.
  always_comb begin
    theta_u = theta;
    prod    = zext_pixel(x_reg) * theta_u;
    addend  = bias_reg ? (theta_u << BIAS_SHIFT) : prod;
    sum     = en_reg ? (acc_reg + addend) : acc_reg;
  end

  assign acc_next = sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= sum;
    end
  end

endmodule

// File: rtl/ip_mac_sequencer.sv
// Sequential replacement for the parallel 81-term inner product: one window in,
// one ROM read per cycle, one shared MAC, result held until accepted.
module ip_mac_sequencer
  import ip_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  ip_mac_sequencer_if.master  bus,
  output logic                busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_FEAT - 1);

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  idx_reg, idx_next;
  pixel_t             win_reg [N_FEAT];
  pixel_t             win_x   [N_FEAT];
  logic [ACC_W-1:0]   hidden_reg;
  logic               res_valid_reg;
  logic               handshake;
  logic               issue;
  pixel_t             x_sel;
  acc_t               acc_next;

  assign handshake = bus.win_valid && (state_reg == S_IDLE);
  assign issue     = (state_reg == S_RUN);

  generate
    for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_win
      assign win_x[gi] = bus.win_data[gi*X_W +: X_W];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          win_reg[gi] <= '0;
        end else if (handshake) begin
          win_reg[gi] <= win_x[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (handshake) begin
          state_next = S_RUN;
          idx_next   = '0;
        end
      end
      S_RUN: begin
        idx_next = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // idx runs one past the last term in DRAIN; keep the mux in range there.
  assign x_sel = (idx_reg < ADDR_W'(N_FEAT)) ? win_reg[idx_reg] : '0;

  ip_mac_unit u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (handshake),
    .en       (issue),
    .bias_sel (idx_reg == '0),
    .x        (x_sel),
    .theta    (acc_t'(bus.theta_data)),
    .acc_next (acc_next)
  );

  // DRAIN is the cycle the last ROM word is present, so capture the MAC's sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hidden_reg    <= '0;
      res_valid_reg <= 1'b0;
    end else if (state_reg == S_DRAIN) begin
      hidden_reg    <= acc_next;
      res_valid_reg <= 1'b1;
    end else if ((state_reg == S_HOLD) && bus.res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

`ifdef IPSEQ_THRESH_OUT_EN
  logic class_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_reg <= 1'b0;
    end else if (state_reg == S_DRAIN) begin
      class_reg <= ~acc_next[ACC_W-1];
    end
  end

  assign bus.class_out = class_reg;
`endif

  assign bus.win_ready  = (state_reg == S_IDLE);
  assign bus.theta_rd   = issue;
  assign bus.theta_addr = issue ? idx_reg : '0;
  assign bus.res_valid  = res_valid_reg;
  assign bus.hidden     = hidden_reg;
  assign busy           = (state_reg != S_IDLE);

endmodule
